// File: rtl/ddr_burst_arbiter_if.sv
// Bundle between the DDR burst arbiter and its requesters / DDR command port.
// The master modport is the arbiter's view; slave is the environment's view.
interface ddr_burst_arbiter_if;
   logic [3:0] req;
   logic [1:0] ch0_wr_bank;
   logic [1:0] ch1_wr_bank;
   logic [1:0] ch0_rd_bank;
   logic [1:0] ch1_rd_bank;
   logic       cmd_ready;
   logic       burst_done;
   logic [3:0] grant;
   logic       cmd_valid;
   logic       cmd_write;
   logic [1:0] cmd_bank;
   logic       cmd_ch;
   logic [3:0] done;
   logic       timeout_err;

   modport master (
      input  req, ch0_wr_bank, ch1_wr_bank, ch0_rd_bank, ch1_rd_bank,
      input  cmd_ready, burst_done,
      output grant, cmd_valid, cmd_write, cmd_bank, cmd_ch, done, timeout_err
   );

   modport slave (
      output req, ch0_wr_bank, ch1_wr_bank, ch0_rd_bank, ch1_rd_bank,
      output cmd_ready, burst_done,
      input  grant, cmd_valid, cmd_write, cmd_bank, cmd_ch, done, timeout_err
   );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Four-requester DDR burst arbiter: round-robin with optional read priority,
// command handshake, burst-completion tracking and a BUSY watchdog.
module ddr_burst_arbiter #(
   parameter int RD_PRIORITY = 1,
   parameter int TIMEOUT     = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   ddr_burst_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);
   localparam bit         RD_FIRST = (RD_PRIORITY != 0);

   state_t     r_state;
   logic [1:0] r_last;
   logic [1:0] r_win;
   logic [9:0] r_cnt;
   logic [3:0] r_grant;
   logic       r_cmd_valid;
   logic       r_cmd_write;
   logic [1:0] r_cmd_bank;
   logic       r_cmd_ch;
   logic [3:0] r_done;
   logic       r_timeout_err;

   logic [3:0] w_mask;
   logic [1:0] w_win;
   logic       w_found;
   logic [1:0] w_bank;

   // Pending reads hide all writes from the search when read priority is on.
   assign w_mask = (RD_FIRST && (|bus.req[3:2])) ? (bus.req & 4'b1100) : bus.req;

   always_comb begin
      w_win   = 2'd0;
      w_found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!w_found && w_mask[r_last + 2'(i)]) begin
            w_win   = r_last + 2'(i);
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      case (w_win)
         2'd0:    w_bank = bus.ch0_wr_bank;
         2'd1:    w_bank = bus.ch1_wr_bank;
         2'd2:    w_bank = bus.ch0_rd_bank;
         default: w_bank = bus.ch1_rd_bank;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_last        <= 2'd3;
         r_win         <= 2'd0;
         r_cnt         <= 10'd0;
         r_grant       <= 4'd0;
         r_cmd_valid   <= 1'b0;
         r_cmd_write   <= 1'b0;
         r_cmd_bank    <= 2'd0;
         r_cmd_ch      <= 1'b0;
         r_done        <= 4'd0;
         r_timeout_err <= 1'b0;
      end else begin
         r_done        <= 4'd0;
         r_timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|bus.req) begin
                  r_win       <= w_win;
                  r_grant     <= 4'b0001 << w_win;
                  r_cmd_valid <= 1'b1;
                  r_cmd_write <= ~w_win[1];
                  r_cmd_ch    <= w_win[0];
                  r_cmd_bank  <= w_bank;
                  r_state     <= GRANT;
               end
            end
            GRANT: begin
               if (bus.cmd_ready) begin
                  r_cmd_valid <= 1'b0;
                  r_cnt       <= 10'd0;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               // A completion on the watchdog's last cycle still wins.
               if (bus.burst_done) begin
                  r_done  <= r_grant;
                  r_grant <= 4'd0;
                  r_last  <= r_win;
                  r_state <= IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_grant       <= 4'd0;
                  r_last        <= r_win;
                  r_state       <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 10'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.grant       = r_grant;
   assign bus.cmd_valid   = r_cmd_valid;
   assign bus.cmd_write   = r_cmd_write;
   assign bus.cmd_bank    = r_cmd_bank;
   assign bus.cmd_ch      = r_cmd_ch;
   assign bus.done        = r_done;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Scoreboard bench: two arbiters (read-priority and plain round-robin) share
// one stimulus stream and are checked against a transaction-level model.
module tb_ddr_burst_arbiter;
   localparam int TO = 20;

   typedef struct packed {
      logic [3:0] grant;
      logic       write;
      logic [1:0] bank;
      logic       ch;
   } cmd_t;

   typedef struct packed {
      logic [3:0] done;
      logic       to;
   } cpl_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'd0;
   logic [1:0] bank [4];
   logic       ready = 1'b0;
   logic       bdone = 1'b0;

   logic [3:0] o_grant [2];
   logic       o_valid [2];
   logic       o_write [2];
   logic [1:0] o_bank  [2];
   logic       o_ch    [2];
   logic [3:0] o_done  [2];
   logic       o_to    [2];

   int n_chk  = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;

   cmd_t eq_cmd0[$], eq_cmd1[$];
   cpl_t eq_cpl0[$], eq_cpl1[$];
   logic [3:0] glog0[$], glog1[$];

   int         m_ph   [2];
   int         m_last [2];
   int         m_busy [2];
   int         m_win  [2];
   logic [3:0] m_grant[2];
   logic       m_valid[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gd
      ddr_burst_arbiter_if ifc ();
      assign ifc.req         = req;
      assign ifc.ch0_wr_bank = bank[0];
      assign ifc.ch1_wr_bank = bank[1];
      assign ifc.ch0_rd_bank = bank[2];
      assign ifc.ch1_rd_bank = bank[3];
      assign ifc.cmd_ready   = ready;
      assign ifc.burst_done  = bdone;
      assign o_grant[g] = ifc.grant;
      assign o_valid[g] = ifc.cmd_valid;
      assign o_write[g] = ifc.cmd_write;
      assign o_bank[g]  = ifc.cmd_bank;
      assign o_ch[g]    = ifc.cmd_ch;
      assign o_done[g]  = ifc.done;
      assign o_to[g]    = ifc.timeout_err;
      ddr_burst_arbiter #(.RD_PRIORITY((g == 0) ? 1 : 0), .TIMEOUT(TO)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (ifc)
      );
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Instance 0 has read priority, instance 1 is plain round-robin.
   function automatic int pick(input int k, input logic [3:0] r, input int last);
      bit rd_only;
      rd_only = (k == 0) && (r[3:2] != 2'b00);
      for (int i = 1; i <= 4; i++) begin
         int c;
         c = (last + i) % 4;
         if (r[c] && (!rd_only || c >= 2)) return c;
      end
      return 0;
   endfunction

   task automatic model_step(input int k);
      cmd_t c;
      cpl_t p;
      int   w;
      if (!rst_n) begin
         m_ph[k] = 0; m_last[k] = 3; m_busy[k] = 0; m_win[k] = 0;
      end else begin
         case (m_ph[k])
            0: if (req != 4'd0) begin
               w = pick(k, req, m_last[k]);
               m_win[k] = w;
               m_ph[k]  = 1;
               c.grant = 4'b0001 << w;
               c.write = (w < 2);
               c.bank  = bank[w];
               c.ch    = (w % 2 == 1);
               if (k == 0) eq_cmd0.push_back(c); else eq_cmd1.push_back(c);
            end
            1: if (ready) begin m_ph[k] = 2; m_busy[k] = 0; end
            default: begin
               m_busy[k]++;
               if (bdone || m_busy[k] == TO) begin
                  p.done = bdone ? (4'b0001 << m_win[k]) : 4'd0;
                  p.to   = !bdone;
                  if (k == 0) eq_cpl0.push_back(p); else eq_cpl1.push_back(p);
                  m_last[k] = m_win[k];
                  m_ph[k]   = 0;
               end
            end
         endcase
      end
      m_grant[k] = (m_ph[k] != 0) ? (4'b0001 << m_win[k]) : 4'd0;
      m_valid[k] = (m_ph[k] == 1);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'd0; ready = 1'b0; bdone = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   task automatic chk_zero(input string nm);
      for (int k = 0; k < 2; k++)
         chk($sformatf("%s[%0d]", nm, k),
             16'({o_grant[k], o_done[k], o_valid[k], o_write[k], o_bank[k], o_ch[k], o_to[k]}),
             16'd0);
   endtask

   // Monitor: per-cycle grant/valid, command hold, and queue-popped events.
   initial begin
      logic p_valid [2];
      cmd_t p_cmd   [2];
      cmd_t cur, e;
      cpl_t ce, ca;
      bit   have;
      p_valid[0] = 1'b0; p_valid[1] = 1'b0;
      p_cmd[0] = '0; p_cmd[1] = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("grant_cyc[%0d]", k), 16'(o_grant[k]), 16'(m_grant[k]));
               chk($sformatf("valid_cyc[%0d]", k), 16'(o_valid[k]), 16'(m_valid[k]));
               cur = {o_grant[k], o_write[k], o_bank[k], o_ch[k]};
               if (o_valid[k] && !p_valid[k]) begin
                  have = 1'b0;
                  if (k == 0) begin
                     glog0.push_back(o_grant[k]);
                     if (eq_cmd0.size() > 0) begin have = 1'b1; e = eq_cmd0.pop_front(); end
                  end else begin
                     glog1.push_back(o_grant[k]);
                     if (eq_cmd1.size() > 0) begin have = 1'b1; e = eq_cmd1.pop_front(); end
                  end
                  chk($sformatf("cmd_expected[%0d]", k), 16'(have), 16'd1);
                  if (have) chk($sformatf("cmd_fields[%0d]", k), 16'(cur), 16'(e));
               end
               if (o_valid[k] && p_valid[k])
                  chk($sformatf("cmd_hold[%0d]", k), 16'(cur), 16'(p_cmd[k]));
               if (o_done[k] != 4'd0 || o_to[k]) begin
                  have = 1'b0;
                  ca = {o_done[k], o_to[k]};
                  if (k == 0) begin
                     if (eq_cpl0.size() > 0) begin have = 1'b1; ce = eq_cpl0.pop_front(); end
                  end else begin
                     if (eq_cpl1.size() > 0) begin have = 1'b1; ce = eq_cpl1.pop_front(); end
                  end
                  chk($sformatf("cpl_expected[%0d]", k), 16'(have), 16'd1);
                  if (have) chk($sformatf("cpl_fields[%0d]", k), 16'(ca), 16'(ce));
               end
               p_valid[k] = o_valid[k];
               p_cmd[k]   = cur;
            end
         end
      end
   end

   initial begin
      int n;
      bit seen;
      for (int i = 0; i < 4; i++) bank[i] = 2'd0;
      do_reset();
      cyc();
      mon_en = 1'b1;
      chk_zero("reset_state");

      // Single ch0 write burst.
      req = 4'b0001; bank[0] = 2'd2;
      cyc();
      chk("w0_grant", 16'(o_grant[0]), 16'h1);
      chk("w0_valid", 16'(o_valid[0]), 16'h1);
      chk("w0_write", 16'(o_write[0]), 16'h1);
      chk("w0_bank",  16'(o_bank[0]),  16'h2);
      chk("w0_ch",    16'(o_ch[0]),    16'h0);
      req = 4'd0; ready = 1'b1;
      cyc();
      chk("w0_busy_valid", 16'(o_valid[0]), 16'h0);
      chk("w0_busy_grant", 16'(o_grant[0]), 16'h1);
      ready = 1'b0;
      cyc(); cyc();
      bdone = 1'b1;
      cyc();
      chk("w0_done", 16'(o_done[0]), 16'h1);
      bdone = 1'b0;
      cyc();
      chk("w0_done_pulse", 16'(o_done[0]), 16'h0);
      chk("w0_idle_grant", 16'(o_grant[0]), 16'h0);

      // All four requesting with immediate ready/done.
      do_reset();
      glog0.delete(); glog1.delete();
      req = 4'b1111; ready = 1'b1; bdone = 1'b1;
      repeat (16) cyc();
      req = 4'd0; ready = 1'b0; bdone = 1'b0;
      cyc(); cyc();
      chk("rr_log_size0", 16'(glog0.size() >= 4), 16'd1);
      chk("rr_log_size1", 16'(glog1.size() >= 5), 16'd1);
      if (glog0.size() >= 4) begin
         chk("rdp_seq0", 16'(glog0[0]), 16'h4);
         chk("rdp_seq1", 16'(glog0[1]), 16'h8);
         chk("rdp_seq2", 16'(glog0[2]), 16'h4);
         chk("rdp_seq3", 16'(glog0[3]), 16'h8);
         for (int i = 0; i < glog0.size(); i++)
            chk("rdp_no_write", 16'(glog0[i] & 4'b0011), 16'h0);
      end
      if (glog1.size() >= 5) begin
         chk("rr_seq0", 16'(glog1[0]), 16'h1);
         chk("rr_seq1", 16'(glog1[1]), 16'h2);
         chk("rr_seq2", 16'(glog1[2]), 16'h4);
         chk("rr_seq3", 16'(glog1[3]), 16'h8);
         chk("rr_seq4", 16'(glog1[4]), 16'h1);
      end

      // Watchdog expiry, then a normal request afterwards.
      do_reset();
      req = 4'b0010; bank[1] = 2'd3;
      cyc();
      ready = 1'b1;
      cyc();
      ready = 1'b0; req = 4'd0;
      n = 0; seen = 1'b0;
      for (int i = 0; i < TO + 5 && !seen; i++) begin
         cyc();
         n++;
         if (o_to[0]) seen = 1'b1;
      end
      chk("to_seen", 16'(seen), 16'd1);
      chk("to_latency", 16'(n), 16'(TO));
      chk("to_grant", 16'(o_grant[0]), 16'h0);
      chk("to_done",  16'(o_done[0]),  16'h0);
      cyc();
      chk("to_pulse", 16'(o_to[0]), 16'h0);
      req = 4'b0001;
      cyc();
      chk("after_to_grant0", 16'(o_grant[0]), 16'h1);
      chk("after_to_grant1", 16'(o_grant[1]), 16'h1);
      req = 4'd0; ready = 1'b1;
      cyc();
      ready = 1'b0; bdone = 1'b1;
      cyc();
      bdone = 1'b0;
      cyc();

      // Completion on the watchdog's final cycle.
      do_reset();
      req = 4'b0100;
      cyc();
      ready = 1'b1;
      cyc();
      ready = 1'b0; req = 4'd0;
      repeat (TO - 1) cyc();
      bdone = 1'b1;
      cyc();
      chk("edge_done", 16'(o_done[0]), 16'h4);
      chk("edge_to",   16'(o_to[0]),   16'h0);
      bdone = 1'b0;
      cyc();

      // Stalled command with toggling inputs, then reset while busy.
      do_reset();
      req = 4'b1000; bank[3] = 2'd1;
      cyc();
      for (int i = 0; i < 50; i++) begin
         req = 4'($urandom); bank[3] = 2'($urandom);
         cyc();
      end
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("stall_valid[%0d]", k), 16'(o_valid[k]), 16'h1);
         chk($sformatf("stall_bank[%0d]", k),  16'(o_bank[k]),  16'h1);
         chk($sformatf("stall_grant[%0d]", k), 16'(o_grant[k]), 16'h8);
      end
      ready = 1'b1;
      cyc();
      ready = 1'b0; req = 4'd0;
      rst_n = 1'b0;
      cyc();
      chk_zero("busy_reset");
      rst_n = 1'b1;
      cyc();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         req   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
         for (int b = 0; b < 4; b++) bank[b] = 2'($urandom);
         ready = 1'($urandom_range(0, 1));
         bdone = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 199) != 0);
         cyc();
      end
      do_reset();
      cyc();
      @(negedge clk);
      #1;
      chk("cmd_q_empty0", 16'(eq_cmd0.size()), 16'd0);
      chk("cmd_q_empty1", 16'(eq_cmd1.size()), 16'd0);
      chk("cpl_q_empty0", 16'(eq_cpl0.size()), 16'd0);
      chk("cpl_q_empty1", 16'(eq_cpl1.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 Parameter: RD_PRIORITY, 1, 1 = read requesters win over write requesters; 0 = plain 4-way round-robin.
REQ-002 Parameter: TIMEOUT, 1023, maximum BUSY cycles before a burst is aborted; range 1..1023 (10-bit counter).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  4  level burst requests; index 0 = ch0 write, 1 = ch1 write, 2 = ch0 read, 3 = ch1 read.
REQ-006 ch0_wr_bank, ch1_wr_bank, ch0_rd_bank, ch1_rd_bank  input  2 each  frame bank per requester, same index order as req.
REQ-007 cmd_ready  input  1  DDR port accepts the command this cycle.
REQ-008 burst_done  input  1  one-cycle pulse: DDR port finished the granted burst.
REQ-009 grant  output  4  one-hot owner of the DDR port; all-zero when idle.
REQ-010 cmd_valid  output  1  command presented to the DDR port.
REQ-011 cmd_write  output  1  1 = write burst (winner index 0/1), 0 = read burst (index 2/3).
REQ-012 cmd_bank  output  2  bank of the winning requester, latched at grant.
REQ-013 cmd_ch  output  1  channel of the winner (0 for index 0/2, 1 for index 1/3).
REQ-014 done  output  4  one-cycle one-hot completion pulse to the owning requester.
REQ-015 timeout_err  output  1  one-cycle pulse when a burst is aborted by the watchdog.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT, BUSY.
REQ-017 In IDLE with req != 0, the block SHALL register the winner, grant, cmd_write, cmd_ch and cmd_bank, assert cmd_valid, and enter GRANT on the next edge (1-cycle req-to-cmd_valid latency).
REQ-018 Winner selection SHALL be round-robin: search order starts at (last_winner + 1) mod 4 and wraps; last_winner resets to 3 so index 0 wins first.
REQ-019 With RD_PRIORITY = 1 and any of req[3:2] set, the winner SHALL be chosen only among read requesters, in the same round-robin order.
REQ-020 In GRANT, cmd_valid and all cmd_* outputs SHALL be held stable until cmd_valid & cmd_ready, then the FSM enters BUSY and cmd_valid deasserts on the same edge.
REQ-021 In BUSY, grant SHALL stay asserted; on burst_done the FSM enters IDLE, grant clears, done pulses for one cycle with the winner bit, and last_winner updates.
REQ-022 A cycle count SHALL run in BUSY; when it reaches TIMEOUT without burst_done, the FSM enters IDLE, grant clears, timeout_err pulses one cycle, done stays 0, and last_winner still updates.
REQ-023 burst_done in the same cycle as the timeout limit SHALL count as normal completion, with no timeout_err.
REQ-024 At least one IDLE cycle SHALL separate two bursts; a request arriving with burst_done is arbitrated in the following IDLE cycle.
REQ-025 Changes in req after entering GRANT SHALL NOT alter grant or cmd_*; a request dropped mid-burst is served to completion.
REQ-026 burst_done in IDLE or GRANT SHALL be ignored with no done pulse; cmd_ready outside GRANT SHALL be ignored.
REQ-027 Bank inputs SHALL be sampled only in the IDLE-to-GRANT cycle; later bank changes do not affect cmd_bank.

Reset
REQ-028 With rst_n low at a clock edge: state = IDLE, grant = 0, cmd_valid = 0, cmd_write = 0, cmd_bank = 0, cmd_ch = 0, done = 0, timeout_err = 0, counter = 0, last_winner = 3.
REQ-029 Reset asserted in GRANT or BUSY SHALL abort the burst with no done or timeout_err pulse.

Verification
REQ-030 req = 4'b0001, ch0_wr_bank = 2 -> next cycle grant = 0001, cmd_valid = 1, cmd_write = 1, cmd_bank = 2, cmd_ch = 0; cmd_ready -> BUSY; burst_done -> done = 0001 for one cycle.
REQ-031 RD_PRIORITY = 1, req = 4'b1111 held, immediate ready/done -> grant sequence 0100, 1000, 0100, 1000; writes are never granted.
REQ-032 RD_PRIORITY = 0, req = 4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Grant, cmd_ready, then no burst_done for TIMEOUT cycles -> timeout_err pulses once, grant = 0, done = 0; next request served normally.
REQ-034 cmd_ready held low for 50 cycles while req and ch1_rd_bank toggle -> cmd_valid and cmd_bank stay stable; then rst_n low in BUSY -> all outputs 0 the next cycle.
